// File: rtl/my_arb16.sv
// my_arb16 - two-requester arbiter/sequencer for the shared 16-bit 2:1 mux.
//
// Picks one winner per cycle (round-robin with a burst limit), drives the
// mux select internally and captures the selected word into a single-entry
// output register with a valid/ready handshake toward the consumer.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   in1/in2    16-bit requester data
//   inX_valid  requester X offers a word
//   inX_ready  requester X word accepted this cycle (valid & ready)
//   out        registered selected word
//   out_src    source of out: 0 = in1, 1 = in2
//   out_valid  out/out_src hold a word
//   out_ready  consumer accepts out when out_valid & out_ready
module my_arb16 #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in1,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [15:0] in2,
  input  logic        in2_valid,
  output logic        in2_ready,
  output logic [15:0] out,
  output logic        out_src,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SRC1 = 2'd1,
    OWN_SRC2 = 2'd2
  } owner_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  owner_t      owner;
  owner_t      last;
  logic [3:0]  burst_cnt;

  logic        space;
  logic        grant_v;
  logic        sel;        // mux select: 1 = in2
  logic [15:0] mux_data;
  logic        xfer;

  // Output register can take a word when empty or draining this cycle.
  assign space = !out_valid || out_ready;

  always_comb begin
    grant_v = 1'b0;
    sel     = 1'b0;
    if (in1_valid && in2_valid) begin
      grant_v = 1'b1;
      if (owner != OWN_NONE && burst_cnt < BURST_LIM)
        sel = (owner == OWN_SRC2);
      else
        sel = (last == OWN_SRC1);
    end else if (in1_valid) begin
      grant_v = 1'b1;
      sel     = 1'b0;
    end else if (in2_valid) begin
      grant_v = 1'b1;
      sel     = 1'b1;
    end
  end

  assign mux_data  = sel ? in2 : in1;
  assign in1_ready = grant_v && !sel && space && !reset;
  assign in2_ready = grant_v &&  sel && space && !reset;
  // The granted source always has valid high, so a ready means a transfer.
  assign xfer      = in1_ready || in2_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_src   <= 1'b0;
      out_valid <= 1'b0;
      owner     <= OWN_NONE;
      burst_cnt <= '0;
      last      <= OWN_SRC2;
    end else if (xfer) begin
      out       <= mux_data;
      out_src   <= sel;
      out_valid <= 1'b1;
      last      <= sel ? OWN_SRC2 : OWN_SRC1;
      if (owner == (sel ? OWN_SRC2 : OWN_SRC1)) begin
        if (burst_cnt < BURST_LIM)
          burst_cnt <= burst_cnt + 4'd1;
      end else begin
        owner     <= sel ? OWN_SRC2 : OWN_SRC1;
        burst_cnt <= 4'd1;
      end
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (!in1_valid && !in2_valid) begin
        owner     <= OWN_NONE;
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_my_arb16.sv
// Directed self-checking bench for my_arb16 (MAX_BURST = 4).
// Inputs change 1 time unit after a rising edge; combinational readies are
// checked before the next edge, registered outputs 1 unit after it.
module tb_my_arb16;

  logic        clk;
  logic        reset;
  logic [15:0] in1;
  logic        in1_valid;
  logic        in1_ready;
  logic [15:0] in2;
  logic        in2_valid;
  logic        in2_ready;
  logic [15:0] out;
  logic        out_src;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;

  my_arb16 #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in1       (in1),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in2       (in2),
    .in2_valid (in2_valid),
    .in2_ready (in2_ready),
    .out       (out),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in1_valid = 1'b1; in2_valid = 1'b1;
    in1 = 16'h1111; in2 = 16'h2222; out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out !== 16'h0000) begin failures++; $display("FAIL reset_out: got %h want 0000", out); end
    checks++;
    if (out_valid !== 1'b0 || out_src !== 1'b0) begin
      failures++; $display("FAIL reset_flags: valid=%b src=%b want 0 0", out_valid, out_src);
    end
    checks++;
    if (in1_ready !== 1'b0 || in2_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: r1=%b r2=%b want 0 0", in1_ready, in2_ready);
    end
    reset = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    in1 = 16'h1234; in1_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in1_ready !== 1'b1 || in2_ready !== 1'b0) begin
      failures++; $display("FAIL single_ready: r1=%b r2=%b want 1 0", in1_ready, in2_ready);
    end
    tick();
    in1_valid = 1'b0;
    checks++;
    if (out !== 16'h1234 || out_src !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL single_out: out=%h src=%b valid=%b want 1234 0 1", out, out_src, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out !== 16'h1234) begin
      failures++; $display("FAIL single_drain: valid=%b out=%h want 0 1234", out_valid, out);
    end
  endtask

  task automatic test_burst;
    logic exp_src;
    do_reset();
    in1 = 16'hAAAA; in2 = 16'h5555; out_ready = 1'b1;
    in1_valid = 1'b1; in2_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_src = ((k / 4) % 2) == 1;
      #1;
      checks++;
      if (in1_ready !== !exp_src || in2_ready !== exp_src) begin
        failures++;
        $display("FAIL burst_ready[%0d]: r1=%b r2=%b want %b %b", k, in1_ready, in2_ready, !exp_src, exp_src);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== exp_src || out !== (exp_src ? 16'h5555 : 16'hAAAA)) begin
        failures++;
        $display("FAIL burst_out[%0d]: src=%b out=%h valid=%b want src %b", k, out_src, out, out_valid, exp_src);
      end
    end
    in1_valid = 1'b0; in2_valid = 1'b0;
    tick();
  endtask

  task automatic test_tie_after_in2;
    do_reset();
    out_ready = 1'b1;
    in2 = 16'h0F0F; in2_valid = 1'b1;
    tick();
    checks++;
    if (out !== 16'h0F0F || out_src !== 1'b1) begin
      failures++; $display("FAIL tie_in2_out: out=%h src=%b want 0f0f 1", out, out_src);
    end
    in2_valid = 1'b0;
    tick();
    in1 = 16'hF0F0; in1_valid = 1'b1; in2_valid = 1'b1;
    #1;
    checks++;
    if (in1_ready !== 1'b1 || in2_ready !== 1'b0) begin
      failures++; $display("FAIL tie_after_idle: r1=%b r2=%b want 1 0", in1_ready, in2_ready);
    end
    tick();
    checks++;
    if (out !== 16'hF0F0 || out_src !== 1'b0) begin
      failures++; $display("FAIL tie_after_idle_out: out=%h src=%b want f0f0 0", out, out_src);
    end
    in1_valid = 1'b0; in2_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b1;
    in1 = 16'hBEEF; in1_valid = 1'b1;
    tick();
    in1_valid = 1'b0;
    in2 = 16'h1111; in2_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in2_ready !== 1'b0 || in1_ready !== 1'b0) begin
        failures++; $display("FAIL bp_ready[%0d]: r1=%b r2=%b want 0 0", k, in1_ready, in2_ready);
      end
      tick();
      checks++;
      if (out !== 16'hBEEF || out_src !== 1'b0 || out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold[%0d]: out=%h src=%b valid=%b want beef 0 1", k, out, out_src, out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in2_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready: r2=%b want 1", in2_ready);
    end
    tick();
    in2_valid = 1'b0;
    checks++;
    if (out !== 16'h1111 || out_src !== 1'b1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_release_out: out=%h src=%b valid=%b want 1111 1 1", out, out_src, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    // out_valid is 1 from the previous scenario
    in1 = 16'h7777; in2 = 16'h8888; in1_valid = 1'b1; in2_valid = 1'b1;
    out_ready = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (in1_ready !== 1'b0 || in2_ready !== 1'b0) begin
      failures++; $display("FAIL rmid_ready: r1=%b r2=%b want 0 0", in1_ready, in2_ready);
    end
    tick();
    checks++;
    if (out !== 16'h0000 || out_valid !== 1'b0 || out_src !== 1'b0) begin
      failures++; $display("FAIL rmid_out: out=%h valid=%b src=%b want 0000 0 0", out, out_valid, out_src);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in1_ready !== 1'b1 || in2_ready !== 1'b0) begin
      failures++; $display("FAIL rmid_tie: r1=%b r2=%b want 1 0", in1_ready, in2_ready);
    end
    tick();
    checks++;
    if (out !== 16'h7777 || out_src !== 1'b0) begin
      failures++; $display("FAIL rmid_tie_out: out=%h src=%b want 7777 0", out, out_src);
    end
    in1_valid = 1'b0; in2_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturate;
    logic [15:0] w;
    do_reset();
    out_ready = 1'b1;
    in2_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      w = 16'h2000 + 16'(k);
      in2 = w;
      #1;
      checks++;
      if (in2_ready !== 1'b1 || in1_ready !== 1'b0) begin
        failures++; $display("FAIL sat_ready[%0d]: r1=%b r2=%b want 0 1", k, in1_ready, in2_ready);
      end
      tick();
      checks++;
      if (out !== w || out_src !== 1'b1 || out_valid !== 1'b1) begin
        failures++; $display("FAIL sat_out[%0d]: out=%h src=%b want %h 1", k, out, out_src, w);
      end
    end
    in1 = 16'hC0DE; in1_valid = 1'b1;
    #1;
    checks++;
    if (in1_ready !== 1'b1 || in2_ready !== 1'b0) begin
      failures++; $display("FAIL sat_switch_ready: r1=%b r2=%b want 1 0", in1_ready, in2_ready);
    end
    tick();
    checks++;
    if (out !== 16'hC0DE || out_src !== 1'b0) begin
      failures++; $display("FAIL sat_switch_out: out=%h src=%b want c0de 0", out, out_src);
    end
    // in1 has a fresh burst now, so it keeps the grant
    #1;
    checks++;
    if (in1_ready !== 1'b1 || in2_ready !== 1'b0) begin
      failures++; $display("FAIL sat_owner_keep: r1=%b r2=%b want 1 0", in1_ready, in2_ready);
    end
    in1_valid = 1'b0; in2_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    in1 = '0; in2 = '0;
    in1_valid = 1'b0; in2_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_tie_after_in2();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
